adc_capture_ctrl: RTL and testbench

Parametrised capture controller for the scope sample RAM. It decimates the incoming ADC sample strobe and writes kept samples into a circular buffer. It arms once enough pre-trigger samples exist, counts a programmable number of post-trigger samples, then flags capture done and reports the trace end address. It adds depth/decimator generalisation, normal/auto/single modes, auto-trigger timeout and an abort input. It sits between the trigger logic and the per-channel sample RAMs; the dump logic reads `trace_end`.

---
 rtl/adc_capture_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - decimating circular-buffer capture controller for the scope sample RAM
// Optional auto-trigger timeout (mode 01) is built only when CAP_AUTO_EN is defined.
module adc_capture_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DEC_W   = 4,
  parameter int AUTO_TO = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              trig,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  input  logic              smpl_vld,
  input  logic              clr_cap_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trace_end,
  output logic              auto_trigd,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DC_W  = (2 ** DEC_W) - 1;

  if (AUTO_TO < 1) begin : g_bad_auto_to
    $error("AUTO_TO must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [DC_W-1:0]     dec_cnt, dec_max;
  logic [ADDR_W:0]     smpl_cnt;
  logic [ADDR_W-1:0]   trig_cnt;
  logic [ADDR_W+1:0]   arm_sum;
  logic                keep, capturing, arm_reach, post_reach, auto_fire;
  logic [ADDR_W-1:0]   last_addr, trace_val;
  logic                clr_cnts, clr_waddr, clr_flag, done_set, trace_ld;

  // Keep one sample when the count reaches 2**decimator - 1.
  assign dec_max   = ~({DC_W{1'b1}} << decimator);
  assign keep      = smpl_vld && (dec_cnt == dec_max);
  assign capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign we        = keep && capturing;
  assign armed     = (state == S_ARMED);
  assign busy      = (state != S_IDLE);

  assign arm_sum    = (ADDR_W+2)'(smpl_cnt) + (ADDR_W+2)'(trig_pos) + (ADDR_W+2)'(1);
  assign arm_reach  = arm_sum >= (ADDR_W+2)'(DEPTH);
  assign post_reach = (trig_cnt + ADDR_W'(1)) == trig_pos;
  // A keep coincident with trig is still a pre-trigger sample.
  assign last_addr  = we ? waddr : waddr - ADDR_W'(1);

`ifdef CAP_AUTO_EN
  localparam int AC_W = $clog2(AUTO_TO + 1);
  logic [AC_W-1:0] auto_cnt;
  logic            auto_set;

  assign auto_fire = (mode == 2'b01) && we && (state == S_ARMED) &&
                     ((auto_cnt + AC_W'(1)) == AC_W'(AUTO_TO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt   <= '0;
      auto_trigd <= 1'b0;
    end else begin
      if (clr_cnts)
        auto_cnt <= '0;
      else if (we && state == S_ARMED)
        auto_cnt <= auto_cnt + AC_W'(1);
      if (clr_flag)
        auto_trigd <= 1'b0;
      else if (auto_set)
        auto_trigd <= 1'b1;
    end
  end
`else
  assign auto_fire  = 1'b0;
  assign auto_trigd = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    clr_cnts  = 1'b0;
    clr_waddr = 1'b0;
    clr_flag  = 1'b0;
    done_set  = 1'b0;
    trace_ld  = 1'b0;
    trace_val = waddr;
`ifdef CAP_AUTO_EN
    auto_set  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt = S_PRE;
          clr_cnts  = 1'b1;
          clr_waddr = 1'b1;
          clr_flag  = 1'b1;
        end
      end
      S_PRE: begin
        if (stop)
          state_nxt = S_IDLE;
        else if (we && arm_reach)
          state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (trig || auto_fire) begin
`ifdef CAP_AUTO_EN
          auto_set = auto_fire && !trig;
`endif
          if (trig_pos != '0) begin
            state_nxt = S_POST;
          end else begin
            state_nxt = S_DONE;
            done_set  = 1'b1;
            trace_ld  = 1'b1;
            trace_val = last_addr;
          end
        end
      end
      S_POST: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (we && post_reach) begin
          state_nxt = S_DONE;
          done_set  = 1'b1;
          trace_ld  = 1'b1;
          trace_val = waddr;
        end
      end
      S_DONE: begin
        if (clr_cap_done) begin
          clr_cnts = 1'b1;
          if (mode == 2'b10) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_PRE;
            clr_flag  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dec_cnt      <= '0;
      waddr        <= '0;
      smpl_cnt     <= '0;
      trig_cnt     <= '0;
      trace_end    <= '0;
      capture_done <= 1'b0;
    end else begin
      state <= state_nxt;

      if (clr_cnts || keep)
        dec_cnt <= '0;
      else if (smpl_vld)
        dec_cnt <= dec_cnt + DC_W'(1);

      if (clr_waddr)
        waddr <= '0;
      else if (we)
        waddr <= waddr + ADDR_W'(1);

      if (clr_cnts)
        smpl_cnt <= '0;
      else if (we && state == S_PRE)
        smpl_cnt <= smpl_cnt + (ADDR_W+1)'(1);

      if (clr_cnts)
        trig_cnt <= '0;
      else if (we && state == S_POST)
        trig_cnt <= trig_cnt + ADDR_W'(1);

      if (trace_ld)
        trace_end <= trace_val;

      if (done_set)
        capture_done <= 1'b1;
      else if (clr_cap_done)
        capture_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - directed scoreboard bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

  localparam int ADDR_W  = 9;
  localparam int DEC_W   = 4;
  localparam int AUTO_TO = 16;
  localparam int DEPTH   = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop, trig, smpl_vld, clr_cap_done;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] trig_pos;
  logic [DEC_W-1:0]  decimator;
  logic              we, armed, capture_done, auto_trigd, busy;
  logic [ADDR_W-1:0] waddr, trace_end;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  int m_addr = 0;
  int m_dec = 0;
  int m_period = 1;
  int m_trace = 0;
  bit m_writing = 1'b0;

  adc_capture_ctrl #(.ADDR_W(ADDR_W), .DEC_W(DEC_W), .AUTO_TO(AUTO_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .trig(trig), .trig_pos(trig_pos), .decimator(decimator),
    .smpl_vld(smpl_vld), .clr_cap_done(clr_cap_done), .we(we), .waddr(waddr),
    .armed(armed), .capture_done(capture_done), .trace_end(trace_end),
    .auto_trigd(auto_trigd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Every RAM write must match the next address the model predicted.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("waddr", waddr, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input int d);
    decimator = DEC_W'(d);
    m_period  = 1 << d;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) begin
      smpl_vld = 1'b1;
      if (m_dec == m_period - 1) begin
        if (m_writing) begin
          exp_q.push_back(m_addr);
          m_addr = (m_addr + 1) % DEPTH;
        end
        m_dec = 0;
      end else begin
        m_dec++;
      end
      tick();
    end
    smpl_vld = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start     = 1'b0;
    m_dec     = 0;
    m_addr    = 0;
    m_writing = 1'b1;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_writing = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cap_done = 1'b1;
    tick();
    clr_cap_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; trig = 1'b0; smpl_vld = 1'b0;
    clr_cap_done = 1'b0; mode = 2'b00; trig_pos = '0; set_dec(0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_armed", armed, 0);
    check("rst_done", capture_done, 0);
    check("rst_trace_end", trace_end, 0);
    check("rst_auto_trigd", auto_trigd, 0);
    check("rst_busy", busy, 0);

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_same_cycle_busy", busy, 0);

    // Basic capture: trig on the write to 299, 256 post samples end at 43.
    trig_pos = 9'd256;
    do_start();
    check("basic_busy", busy, 1);
    check("basic_waddr_start", waddr, 0);
    samples(255);
    check("basic_not_armed_255", armed, 0);
    samples(1);
    check("basic_armed_256", armed, 1);
    samples(43);
    trig = 1'b1;
    samples(1);
    trig = 1'b0;
    check("basic_post_armed", armed, 0);
    samples(255);
    check("basic_done_early", capture_done, 0);
    samples(1);
    m_writing = 1'b0;
    m_trace = 43;
    check("basic_done", capture_done, 1);
    check("basic_trace_end", trace_end, m_trace);
    smpl_vld = 1'b1;
    @(negedge clk);
    check("basic_we_in_done", we, 0);
    tick();
    smpl_vld = 1'b0;

    // Normal mode restart keeps waddr running from trace_end + 1.
    pulse_clr();
    check("restart_done_cleared", capture_done, 0);
    check("restart_busy", busy, 1);
    check("restart_waddr", waddr, m_trace + 1);
    pulse_stop();
    check("restart_stop_idle", busy, 0);

    // Decimation: one write per 8 samples, trig ignored while in PRE.
    set_dec(3);
    trig_pos = 9'd500;
    do_start();
    trig = 1'b1;
    samples(95);
    trig = 1'b0;
    check("dec_not_armed_95", armed, 0);
    check("dec_waddr_95", waddr, 11);
    samples(1);
    check("dec_armed_96", armed, 1);
    pulse_stop();
    check("dec_stop_armed", armed, 0);
    set_dec(0);

    // Zero post-trigger samples, single mode.
    mode = 2'b10;
    trig_pos = '0;
    do_start();
    samples(511);
    check("zero_not_armed_511", armed, 0);
    samples(1);
    check("zero_armed_512", armed, 1);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    m_writing = 1'b0;
    m_trace = 511;
    check("zero_done", capture_done, 1);
    check("zero_trace_end", trace_end, m_trace);
    check("zero_armed_cleared", armed, 0);
    pulse_clr();
    check("single_busy", busy, 0);
    check("single_done_cleared", capture_done, 0);

    // Auto timeout after AUTO_TO writes in ARMED without a trigger.
    mode = 2'b01;
    trig_pos = 9'd4;
    do_start();
    samples(508);
    check("auto_armed", armed, 1);
    samples(15);
    check("auto_armed_15", armed, 1);
    samples(1);
`ifdef CAP_AUTO_EN
    check("auto_forced_post", armed, 0);
    samples(4);
    m_writing = 1'b0;
    m_trace = 15;
    check("auto_done", capture_done, 1);
    check("auto_trace_end", trace_end, m_trace);
    check("auto_trigd_set", auto_trigd, 1);
    pulse_clr();
`else
    check("auto_off_still_armed", armed, 1);
    samples(40);
    check("auto_off_armed_long", armed, 1);
    check("auto_off_trigd", auto_trigd, 0);
`endif
    pulse_stop();
    check("auto_stop_idle", busy, 0);

    // Abort in POST: back to IDLE with no completion.
    mode = 2'b00;
    trig_pos = 9'd8;
    do_start();
    samples(504);
    check("abort_armed", armed, 1);
    trig = 1'b1;
    samples(1);
    trig = 1'b0;
    samples(3);
    check("abort_in_post", busy && !armed, 1);
    pulse_stop();
    check("abort_busy", busy, 0);
    check("abort_done", capture_done, 0);
    check("abort_trace_end", trace_end, m_trace);

    // Asynchronous reset while ARMED.
    do_start();
    samples(504);
    check("reset_pre_armed", armed, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_we", we, 0);
    check("async_waddr", waddr, 0);
    check("async_armed", armed, 0);
    check("async_done", capture_done, 0);
    check("async_trace_end", trace_end, 0);
    check("async_auto_trigd", auto_trigd, 0);
    check("async_busy", busy, 0);
    m_writing = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("writes_all_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
